// File: rtl/mem_burst_arbiter.sv
// Arbitrates I-cache line bursts and LSB loads/stores onto a one-byte-per-cycle RAM port.
// Handles access size, sign extension, speculative flush and IO-space store back-pressure.
module mem_burst_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int FETCH_BYTES = 16,
    parameter int IO_SEL_HI   = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [7:0]               byte_in,
    input  logic                     io_buffer_full,
    output logic                     ram_enable,
    output logic                     lw_type,
    output logic [ADDR_W-1:0]        addr,
    output logic [7:0]               byte_out,
    input  logic                     fetch_enable,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_valid,
    output logic [8*FETCH_BYTES-1:0] fetch_data,
    input  logic                     lsb_enable,
    input  logic                     lsb_rw,
    input  logic [1:0]               lsb_size,
    input  logic                     lsb_signed,
    input  logic [ADDR_W-1:0]        lsb_addr,
    input  logic [31:0]              lsb_data,
    output logic                     lsb_valid,
    output logic [31:0]              read_data,
    input  logic                     flush
);

    localparam int CNT_W  = $clog2(FETCH_BYTES + 2);
    localparam int LINE_W = 8 * (FETCH_BYTES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  base;
    logic [2:0]         n_bytes;
    logic               sgn;
    logic [31:0]        st_data;
    logic [23:0]        ld_buf;
    logic [LINE_W-1:0]  line_buf;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   burst_len;
    logic [ADDR_W-1:0]  st_addr;
    logic [7:0]         st_byte;
    logic               io_accept;
    logic               io_next;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Loaded bytes arrive LSB first, so the most recent byte is the top of the result.
    function automatic logic [31:0] extend_load(input logic [7:0] last, input logic [23:0] prev,
                                                input logic [2:0] n, input logic s);
        case (n)
            3'd1:    return {{24{s & last[7]}}, last};
            3'd2:    return {{16{s & last[7]}}, last, prev[23:16]};
            default: return {last, prev};
        endcase
    endfunction

    always_comb begin
        cnt_inc   = cnt + CNT_W'(1);
        burst_len = (state == FETCH) ? CNT_W'(FETCH_BYTES) : CNT_W'(n_bytes);
        st_addr   = base + ADDR_W'(cnt);
        st_byte   = st_data[{cnt[1:0], 3'b000} +: 8];
        io_accept = (lsb_addr[IO_SEL_HI -: 2] == 2'b11);
        io_next   = (st_addr[IO_SEL_HI -: 2] == 2'b11);
    end

    // NOTE: every register below is state, so it is assigned only with <= to keep edge semantics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            base        <= '0;
            n_bytes     <= '0;
            sgn         <= 1'b0;
            st_data     <= '0;
            ld_buf      <= '0;
            line_buf    <= '0;
            ram_enable  <= 1'b0;
            lw_type     <= 1'b0;
            addr        <= '0;
            byte_out    <= '0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            lsb_valid   <= 1'b0;
            read_data   <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (lsb_enable) begin
                        base    <= lsb_addr;
                        n_bytes <= size_to_n(lsb_size);
                        sgn     <= lsb_signed;
                        st_data <= lsb_data;
                        addr    <= lsb_addr;
                        if (!lsb_rw) begin
                            state    <= STORE;
                            lw_type  <= 1'b1;
                            byte_out <= lsb_data[7:0];
                            // cnt counts bytes actually put on the bus; a held IO byte is retried.
                            if (io_accept && io_buffer_full) begin
                                ram_enable <= 1'b0;
                                cnt        <= '0;
                            end else begin
                                ram_enable <= 1'b1;
                                cnt        <= CNT_W'(1);
                            end
                        end else begin
                            state      <= LOAD;
                            lw_type    <= 1'b0;
                            ram_enable <= 1'b1;
                            cnt        <= '0;
                        end
                    end else if (fetch_enable && !flush) begin
                        state      <= FETCH;
                        addr       <= fetch_addr;
                        ram_enable <= 1'b1;
                        lw_type    <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        ram_enable <= 1'b0;
                        lw_type    <= 1'b0;
                        addr       <= '0;
                    end
                end

                FETCH, LOAD: begin
                    if (flush) begin
                        state      <= IDLE;
                        ram_enable <= 1'b0;
                        lw_type    <= 1'b0;
                        addr       <= '0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc < burst_len) begin
                            addr <= addr + ADDR_W'(1);
                        end else if (cnt_inc == burst_len) begin
                            ram_enable <= 1'b0;
                        end
                        // Read data trails its address by one cycle, so capture starts on the second edge.
                        if (cnt == burst_len) begin
                            state <= DONE;
                            if (state == FETCH) begin
                                fetch_valid <= 1'b1;
                                fetch_data  <= {byte_in, line_buf};
                            end else begin
                                lsb_valid <= 1'b1;
                                read_data <= extend_load(byte_in, ld_buf, n_bytes, sgn);
                            end
                        end else if (cnt != '0) begin
                            if (state == FETCH) begin
                                line_buf <= {byte_in, line_buf[LINE_W-1:8]};
                            end else begin
                                ld_buf <= {byte_in, ld_buf[23:8]};
                            end
                        end
                    end
                end

                STORE: begin
                    if (cnt == CNT_W'(n_bytes)) begin
                        state      <= DONE;
                        lsb_valid  <= 1'b1;
                        ram_enable <= 1'b0;
                        lw_type    <= 1'b0;
                    end else begin
                        addr     <= st_addr;
                        byte_out <= st_byte;
                        if (io_next && io_buffer_full) begin
                            ram_enable <= 1'b0;
                        end else begin
                            ram_enable <= 1'b1;
                            cnt        <= cnt_inc;
                        end
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                    lsb_valid   <= 1'b0;
                    cnt         <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: fetch bursts, sized loads, stores, IO hold, flush, reset, rdy.
// A small RAM model answers reads one cycle after the address and logs every write.
module tb_mem_burst_arbiter;

    localparam int ADDR_W = 32;
    localparam int FB     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [7:0]        byte_in;
    logic              io_buffer_full;
    logic              ram_enable;
    logic              lw_type;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        byte_out;
    logic              fetch_enable;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [8*FB-1:0]   fetch_data;
    logic              lsb_enable;
    logic              lsb_rw;
    logic [1:0]        lsb_size;
    logic              lsb_signed;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_data;
    logic              lsb_valid;
    logic [31:0]       read_data;
    logic              flush;

    mem_burst_arbiter #(.ADDR_W(ADDR_W), .FETCH_BYTES(FB), .IO_SEL_HI(17)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .byte_in(byte_in), .io_buffer_full(io_buffer_full),
        .ram_enable(ram_enable), .lw_type(lw_type), .addr(addr), .byte_out(byte_out),
        .fetch_enable(fetch_enable), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .lsb_enable(lsb_enable), .lsb_rw(lsb_rw), .lsb_size(lsb_size),
        .lsb_signed(lsb_signed), .lsb_addr(lsb_addr), .lsb_data(lsb_data), .lsb_valid(lsb_valid),
        .read_data(read_data), .flush(flush)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM contents: 0x1xx holds its low address byte, 0x40 holds 0x85, elsewhere low byte ^ (addr[11:8]<<4).
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (a == 32'h40) return 8'h85;
        if (a[11:8] == 4'h1) return a[7:0];
        return a[7:0] ^ {a[11:8], 4'h0};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        writes[$];
    logic [7:0] rd_pipe = 8'h00;
    int         fv_pulses = 0;

    always @(negedge clk) begin
        byte_in = rd_pipe;
        rd_pipe = ram_byte(addr);
        if (ram_enable && lw_type) writes.push_back('{a: addr, d: byte_out});
        if (fetch_valid) fv_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lsb(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!lsb_valid && n < 40);
    endtask

    task automatic wait_fetch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fetch_valid && n < 40);
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] exp, input int lat);
        int n;
        lsb_enable = 1'b1;
        lsb_rw     = 1'b1;
        lsb_size   = sz;
        lsb_signed = sgn;
        lsb_addr   = a;
        tick();
        lsb_enable = 1'b0;
        lsb_signed = ~sgn;
        lsb_size   = 2'd0;
        lsb_addr   = 32'h0;
        check({tag, "_start"}, addr, a);
        wait_lsb(n);
        check({tag, "_lat"}, n, lat);
        check(tag, read_data, exp);
        tick();
    endtask

    task automatic check_writes(input string tag, input logic [31:0] a0, input logic [31:0] data, input int n);
        check({tag, "_count"}, writes.size(), n);
        for (int k = 0; k < n && k < writes.size(); k++) begin
            check({tag, "_waddr"}, writes[k].a, a0 + k);
            check({tag, "_wdata"}, writes[k].d, data[8*k +: 8]);
        end
    endtask

    initial begin
        int n;
        logic [127:0] exp_line;

        rst            = 1'b1;
        rdy            = 1'b1;
        byte_in        = 8'h00;
        io_buffer_full = 1'b0;
        fetch_enable   = 1'b0;
        fetch_addr     = '0;
        lsb_enable     = 1'b0;
        lsb_rw         = 1'b0;
        lsb_size       = 2'd0;
        lsb_signed     = 1'b0;
        lsb_addr       = '0;
        lsb_data       = '0;
        flush          = 1'b0;

        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_ram_enable", ram_enable, 1'b0);
        check("rst_addr", addr, 32'h0);
        check("rst_fetch_data", fetch_data, 128'h0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_valids", {fetch_valid, lsb_valid, lw_type}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Line fetch at 0x100: consecutive addresses, valid 17 edges after accept.
        fetch_enable = 1'b1;
        fetch_addr   = 32'h100;
        tick();
        fetch_enable = 1'b0;
        check("fetch_accept_en", ram_enable, 1'b1);
        check("fetch_accept_addr", addr, 32'h100);
        check("fetch_lw_type", lw_type, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
            if (n < 16) check("fetch_addr", addr, 32'h100 + n);
            if (n == 16) check("fetch_en_drop", ram_enable, 1'b0);
            if (n == 16) check("fetch_no_early_valid", fetch_valid, 1'b0);
        end while (!fetch_valid && n < 40);
        check("fetch_lat", n, 17);
        check("fetch_data", fetch_data, 128'h0F0E0D0C0B0A09080706050403020100);
        tick();
        check("fetch_valid_clear", fetch_valid, 1'b0);

        // Sized loads with and without sign extension.
        do_load("ld_b_s",  2'd0, 1'b1, 32'h40, 32'hFFFFFF85, 2);
        do_load("ld_b_u",  2'd0, 1'b0, 32'h40, 32'h00000085, 2);
        do_load("ld_w",    2'd2, 1'b0, 32'hF0, 32'hF3F2F1F0, 5);
        do_load("ld_h_s",  2'd1, 1'b1, 32'hF8, 32'hFFFFF9F8, 3);
        do_load("ld_h_u",  2'd1, 1'b0, 32'hF8, 32'h0000F9F8, 3);
        do_load("ld_sz3",  2'd3, 1'b1, 32'hA0, 32'hA3A2A1A0, 5);

        // Store and fetch requested together: store wins, fetch waits until after DONE.
        writes.delete();
        lsb_enable   = 1'b1;
        lsb_rw       = 1'b0;
        lsb_size     = 2'd2;
        lsb_addr     = 32'h20;
        lsb_data     = 32'hDEADBEEF;
        fetch_enable = 1'b1;
        fetch_addr   = 32'h200;
        tick();
        lsb_enable = 1'b0;
        lsb_data   = 32'h0;
        check("st_lw_type", lw_type, 1'b1);
        check("st_first", {ram_enable, addr, byte_out}, {1'b1, 32'h20, 8'hEF});
        wait_lsb(n);
        check("st_lat", n, 4);
        check("st_done_lw", {ram_enable, lw_type}, 2'b00);
        tick();
        check("st_no_fetch_in_done", ram_enable, 1'b0);
        tick();
        fetch_enable = 1'b0;
        check("fetch_after_st", {ram_enable, lw_type, addr}, {2'b10, 32'h200});
        check_writes("st_word", 32'h20, 32'hDEADBEEF, 4);
        wait_fetch(n);
        check("fetch2_lat", n, 17);
        for (int k = 0; k < FB; k++) exp_line[8*k +: 8] = 8'h20 | 8'(k);
        check("fetch2_data", fetch_data, exp_line);
        tick();

        // IO-space store held three cycles by io_buffer_full.
        writes.delete();
        io_buffer_full = 1'b1;
        lsb_enable     = 1'b1;
        lsb_rw         = 1'b0;
        lsb_size       = 2'd0;
        lsb_addr       = 32'h30000;
        lsb_data       = 32'h99887741;
        tick();
        lsb_enable = 1'b0;
        lsb_data   = 32'h0;
        check("io_hold0", ram_enable, 1'b0);
        tick();
        check("io_hold1", ram_enable, 1'b0);
        tick();
        check("io_hold2", ram_enable, 1'b0);
        io_buffer_full = 1'b0;
        tick();
        check("io_write", {ram_enable, lw_type, addr, byte_out}, {2'b11, 32'h30000, 8'h41});
        tick();
        check("io_valid", lsb_valid, 1'b1);
        tick();
        check_writes("io_st", 32'h30000, 32'h41, 1);

        // Non-IO store ignores io_buffer_full.
        writes.delete();
        io_buffer_full = 1'b1;
        lsb_enable     = 1'b1;
        lsb_size       = 2'd1;
        lsb_addr       = 32'h10000;
        lsb_data       = 32'hCAFE1234;
        tick();
        lsb_enable = 1'b0;
        check("nonio_first", ram_enable, 1'b1);
        wait_lsb(n);
        check("nonio_lat", n, 2);
        tick();
        io_buffer_full = 1'b0;
        check_writes("nonio_st", 32'h10000, 32'h1234, 2);

        // Flush on the 5th FETCH edge, with a load pending.
        fv_pulses    = 0;
        fetch_enable = 1'b1;
        fetch_addr   = 32'h100;
        tick();
        fetch_enable = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("flush_pre_addr", addr, 32'h104);
        flush      = 1'b1;
        lsb_enable = 1'b1;
        lsb_rw     = 1'b1;
        lsb_size   = 2'd2;
        lsb_signed = 1'b0;
        lsb_addr   = 32'hF0;
        tick();
        flush = 1'b0;
        check("flush_idle", {ram_enable, lw_type}, 2'b00);
        tick();
        lsb_enable = 1'b0;
        check("flush_load_accept", {ram_enable, addr}, {1'b1, 32'hF0});
        wait_lsb(n);
        check("flush_load_lat", n, 5);
        check("flush_load_data", read_data, 32'hF3F2F1F0);
        tick();
        check("flush_no_fetch_valid", fv_pulses, 0);

        // Flush in IDLE blocks fetch acceptance.
        flush        = 1'b1;
        fetch_enable = 1'b1;
        fetch_addr   = 32'h100;
        tick();
        check("flush_blocks_fetch", ram_enable, 1'b0);
        flush = 1'b0;
        tick();
        fetch_enable = 1'b0;
        check("fetch_after_unflush", {ram_enable, addr}, {1'b1, 32'h100});

        // Reset mid-fetch at byte 7, then a fresh fetch at a new base.
        for (int k = 0; k < 7; k++) tick();
        check("rst_pre_addr", addr, 32'h107);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_en", {ram_enable, lw_type, fetch_valid, lsb_valid}, 4'b0000);
        check("rst_mid_addr", addr, 32'h0);
        check("rst_mid_byte_out", byte_out, 8'h00);
        check("rst_mid_fetch_data", fetch_data, 128'h0);
        check("rst_mid_read_data", read_data, 32'h0);
        @(negedge clk);
        rst       = 1'b1;
        fv_pulses = 0;
        tick();
        fetch_enable = 1'b1;
        fetch_addr   = 32'h300;
        tick();
        fetch_enable = 1'b0;
        check("fetch3_accept", {ram_enable, addr}, {1'b1, 32'h300});
        wait_fetch(n);
        check("fetch3_lat", n, 17);
        for (int k = 0; k < FB; k++) exp_line[8*k +: 8] = 8'h30 | 8'(k);
        check("fetch3_data", fetch_data, exp_line);
        tick();
        check("fetch3_one_pulse", fv_pulses, 1);

        // rdy low freezes acceptance and holds the valid pulse.
        rdy        = 1'b0;
        lsb_enable = 1'b1;
        lsb_rw     = 1'b1;
        lsb_size   = 2'd0;
        lsb_signed = 1'b0;
        lsb_addr   = 32'h40;
        tick();
        tick();
        check("rdy_no_accept", ram_enable, 1'b0);
        rdy = 1'b1;
        tick();
        lsb_enable = 1'b0;
        check("rdy_accept", {ram_enable, addr}, {1'b1, 32'h40});
        wait_lsb(n);
        check("rdy_load_lat", n, 2);
        rdy = 1'b0;
        tick();
        tick();
        check("rdy_hold_valid", {lsb_valid, read_data}, {1'b1, 32'h85});
        rdy = 1'b1;
        tick();
        check("rdy_valid_clear", lsb_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
Parametrised successor to the single-channel byte-serial memory controller. It arbitrates the I-cache and the LSB onto the one-byte-per-cycle RAM port. I-cache requests are line-sized bursts of FETCH_BYTES. The block adds:
- per-access size and sign handling;
- a speculative-abort input;
- stalling on io_buffer_full only for IO-space stores.

Parameters:
ADDR_W, 32, address width of all address ports.
FETCH_BYTES, 16, bytes per I-cache burst; power of two, 4..64.
IO_SEL_HI, 17, high bit of the IO-space selector; IO space when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
rdy  in  1  global ready; low freezes all state and outputs.
byte_in  in  8  RAM read data, valid one cycle after its address is presented.
io_buffer_full  in  1  IO write buffer full.
ram_enable  out  1  RAM access strobe.
lw_type  out  1  1 = RAM write, 0 = RAM read.
addr  out  ADDR_W  RAM byte address.
byte_out  out  8  RAM write data.
fetch_enable  in  1  I-cache line request.
fetch_addr  in  ADDR_W  line base address, FETCH_BYTES-aligned.
fetch_valid  out  1  one-cycle pulse: line ready.
fetch_data  out  8*FETCH_BYTES  line data; byte k at bits [8k+7:8k].
lsb_enable  in  1  LSB request.
lsb_rw  in  1  0 = store, 1 = load.
lsb_size  in  2  0 = byte, 1 = half, 2 = word.
lsb_signed  in  1  sign-extend load result.
lsb_addr  in  ADDR_W  access address.
lsb_data  in  32  store data.
lsb_valid  out  1  one-cycle pulse: access complete.
read_data  out  32  load result.
flush  in  1  misprediction abort.

Behaviour:
Reset and stall
- rst low (asynchronous): state IDLE, all outputs 0, fetch_data 0, counters 0.
- rdy low: nothing changes, outputs held.

States: IDLE, FETCH, LOAD, STORE, DONE.
- N = 1, 2 or 4 for lsb_size 0, 1, 2; lsb_size 3 is treated as 2.
- lsb_size, lsb_signed, lsb_data and the address are latched on accept. Inputs may change afterwards.

IDLE arbitration (each edge):
- lsb_enable & !lsb_rw takes STORE.
- else lsb_enable & lsb_rw takes LOAD.
- else fetch_enable & !flush takes FETCH.
- else ram_enable=0, addr=0.
- The accepting edge sets addr to the base address, ram_enable=1, and lw_type (1 for STORE, 0 otherwise).

LOAD and FETCH (reads):
- addr increments by 1 each edge until base+N-1 (or base+FETCH_BYTES-1) has been presented.
- byte_in is captured one edge after its address.
- ram_enable drops the edge after the last address.
- Completion is N+1 edges after accept (FETCH_BYTES+1 for fetch).
- At completion: pulse the valid output, move to DONE, drive read_data:
  - zero-extended, or
  - sign-extended from bit 8N-1 when lsb_signed.

STORE:
- byte_out = lsb_data[8k+7:8k] together with addr=base+k, for k = 0..N-1.
- lsb_valid is set, and ram_enable/lw_type cleared, N edges after accept.
- IO hold: if the byte about to be presented targets IO space and io_buffer_full=1 at that edge, then next cycle ram_enable=0, k holds, and the write is retried. Non-IO stores ignore io_buffer_full.

DONE:
- Lasts exactly one cycle, then IDLE; valid pulses clear there.
- Requests are never accepted in DONE.
- The client must drop its enable on the edge ending the valid cycle.

flush:
- Sampled every edge. In FETCH or LOAD it forces IDLE next edge, with ram_enable=0, lw_type=0, no valid pulse, and the partial data discarded.
- Never affects STORE.
- In IDLE it blocks fetch acceptance only.

Other rules:
- addr wraps modulo 2^ADDR_W.
- Reset asserted mid-burst aborts immediately; no valid pulse follows.

Test Plan:
- Reset low mid-FETCH at byte 7 -> all outputs 0 within the same cycle; after release the next fetch starts at its new base with no stale fetch_valid.
- fetch_enable, fetch_addr=0x100, FETCH_BYTES=16, RAM[k]=k -> addr 0x100..0x10F on consecutive cycles; fetch_valid pulses 17 edges after accept; fetch_data=0x0F0E...0100.
- Load lsb_size=0, lsb_signed=1, addr 0x40, RAM=0x85 -> read_data=0xFFFFFF85, lsb_valid 2 edges after accept; with lsb_signed=0 -> 0x00000085.
- lsb_enable (store, word 0xDEADBEEF @0x20) and fetch_enable asserted in the same cycle -> store wins; writes EF, BE, AD, DE to 0x20..0x23; fetch is accepted only after DONE.
- Store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> ram_enable stays 0 for 3 cycles, then a single write; a non-IO store with io_buffer_full=1 proceeds unstalled.
- flush asserted at the 5th FETCH edge -> IDLE next edge, ram_enable=0, no fetch_valid; an LSB load pending at the same time is accepted on the following IDLE edge.
